// File: rtl/bsalu_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
package bsalu_pkg;

  localparam int unsigned OPSEL_W = 3;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bsalu_bit_counter.sv
// Loadable bit-index up-counter with a registered "last bit" flag.
//   clk, rst_n : clock, synchronous active-low reset
//   i_load     : restart at index 0
//   i_inc      : advance one bit
//   o_idx      : current bit index
//   o_last     : high while o_idx == WIDTH-1
module bsalu_bit_counter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_idx,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_idx;
  logic             r_last;
  logic [CNT_W-1:0] w_idx_inc;

  assign w_idx_inc = r_idx + CNT_W'(1);

  // Flag is computed from the incremented value so it is valid in the same cycle as the index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (i_inc) begin
      r_idx  <= w_idx_inc;
      r_last <= (w_idx_inc == LAST_IDX);
    end
  end

  assign o_idx  = r_idx;
  assign o_last = r_last;

endmodule

// File: rtl/bitserial_alu_seq.sv
// Drives an external 1-bit ALU slice bit-serially (LSB first) to perform one
// WIDTH-bit operation per request, chaining slice cout into the next cin.
// Optional macro BSALU_FLAGS_EN adds rsp_zero / rsp_ovf result flags.
//   req_*     : request handshake and operands (accepted only in IDLE)
//   sl_*      : registered slice drive (op1/op2/cin/opsel/mode), slice result/cout
//   rsp_*     : response handshake, assembled result and MSB carry out
//   busy      : operation in progress or awaiting response handshake
module bitserial_alu_seq
  import bsalu_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [OPSEL_W-1:0] req_opsel,
  input  logic               req_mode,
  input  logic               req_cin,
  output logic               sl_op1,
  output logic               sl_op2,
  output logic               sl_cin,
  output logic [OPSEL_W-1:0] sl_opsel,
  output logic               sl_mode,
  input  logic               sl_result,
  input  logic               sl_cout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_cout,
`ifdef BSALU_FLAGS_EN
  output logic               rsp_zero,
  output logic               rsp_ovf,
`endif
  output logic               busy
);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_accept;
  logic               w_run;
  logic               w_last_step;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_acc_next;
  logic               r_carry;
  logic [OPSEL_W-1:0] r_opsel;
  logic               r_mode;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_busy;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_cout;

  logic [CNT_W-1:0]   w_idx;
  logic               w_last;

  bsalu_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_inc  (w_run),
    .o_idx  (w_idx),
    .o_last (w_last)
  );

  // Next-state decode; r_req_ready gates accept so the post-reset cycle cannot accept.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_run        = 1'b0;
    w_last_step  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept     = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (w_last) begin
          w_last_step  = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Result accumulator with the current slice bit merged in at idx.
  always_comb begin
    w_acc_next        = r_acc;
    w_acc_next[w_idx] = sl_result;
  end

  // State register and datapath; operands shift right so bit 0 always feeds the slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_carry      <= 1'b0;
      r_opsel      <= '0;
      r_mode       <= 1'b0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cout   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == ST_IDLE);
      r_rsp_valid <= (w_next_state == ST_DONE);
      r_busy      <= (w_next_state != ST_IDLE);
      if (w_accept) begin
        r_a     <= req_a;
        r_b     <= req_b;
        r_opsel <= req_opsel;
        r_mode  <= req_mode;
        r_carry <= req_cin;
      end else if (w_run) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_acc <= w_acc_next;
        // Carry is cleared after the MSB so sl_cin reads 0 once back in IDLE.
        r_carry <= w_last_step ? 1'b0 : sl_cout;
        if (w_last_step) begin
          r_rsp_result <= w_acc_next;
          r_rsp_cout   <= sl_cout;
        end
      end
    end
  end

`ifdef BSALU_FLAGS_EN
  logic r_rsp_zero;
  logic r_rsp_ovf;

  // Flags latch with the result; overflow is carry-in vs carry-out of the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_zero <= 1'b0;
      r_rsp_ovf  <= 1'b0;
    end else if (w_last_step) begin
      r_rsp_zero <= (w_acc_next == '0);
      r_rsp_ovf  <= (r_mode == MODE_ARITH) ? (r_carry ^ sl_cout) : 1'b0;
    end
  end

  assign rsp_zero = r_rsp_zero;
  assign rsp_ovf  = r_rsp_ovf;
`endif

  assign req_ready  = r_req_ready;
  assign sl_op1     = r_a[0];
  assign sl_op2     = r_b[0];
  assign sl_cin     = r_carry;
  assign sl_opsel   = r_opsel;
  assign sl_mode    = r_mode;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_cout   = r_rsp_cout;
  assign busy       = r_busy;

endmodule

// File: tb/tb_bitserial_alu_seq.sv
// Scoreboard bench for bitserial_alu_seq with a behavioural slice model.
module tb_bitserial_alu_seq;
  import bsalu_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [2:0]   req_opsel;
  logic         req_mode;
  logic         req_cin;
  logic         sl_op1, sl_op2, sl_cin, sl_mode;
  logic [2:0]   sl_opsel;
  logic         sl_result, sl_cout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_cout;
  logic         busy;
`ifdef BSALU_FLAGS_EN
  logic         rsp_zero, rsp_ovf;
`endif

  always #5 clk = ~clk;

  bitserial_alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opsel  (req_opsel),
    .req_mode   (req_mode),
    .req_cin    (req_cin),
    .sl_op1     (sl_op1),
    .sl_op2     (sl_op2),
    .sl_cin     (sl_cin),
    .sl_opsel   (sl_opsel),
    .sl_mode    (sl_mode),
    .sl_result  (sl_result),
    .sl_cout    (sl_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
`ifdef BSALU_FLAGS_EN
    .rsp_zero   (rsp_zero),
    .rsp_ovf    (rsp_ovf),
`endif
    .busy       (busy)
  );

  // Slice model: full adder in arithmetic mode, XOR with cout = op1 in logic mode.
  logic [1:0] fa_sum;
  always_comb begin
    fa_sum = 2'(sl_op1) + 2'(sl_op2) + 2'(sl_cin);
    if (sl_mode == MODE_ARITH) begin
      sl_result = fa_sum[0];
      sl_cout   = fa_sum[1];
    end else begin
      sl_result = sl_op1 ^ sl_op2;
      sl_cout   = sl_op1;
    end
  end

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, mode;
    logic [2:0]   opsel;
    logic [W-1:0] res;
    logic         cout, zero, ovf;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_mode = 1;   // 0 = low, 1 = high, 2 = random
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole-word reference: plain addition or XOR over the full operands.
  function automatic exp_t model(input logic [W-1:0] a, b, input logic cin, mode,
                                 input logic [2:0] op);
    exp_t e;
    logic [W:0] s;
    e.a = a; e.b = b; e.cin = cin; e.mode = mode; e.opsel = op; e.acc_cyc = 0;
    if (mode == MODE_ARITH) begin
      s      = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
      e.res  = s[W-1:0];
      e.cout = s[W];
      e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    end else begin
      e.res  = a ^ b;
      e.cout = a[W-1];
      e.ovf  = 1'b0;
    end
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Carry entering bit k, from the low k bits of the operands.
  function automatic logic exp_cin(input exp_t e, input int k);
    logic [63:0] mask, s;
    if (e.mode == MODE_ARITH) begin
      mask = (64'd1 << k) - 64'd1;
      s    = (64'(e.a) & mask) + (64'(e.b) & mask) + 64'(e.cin);
      return s[k];
    end
    return (k == 0) ? e.cin : e.a[k-1];
  endfunction

  // Sole driver of rsp_ready.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: latency, per-bit slice drive, idle drive, and response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (rst_n) begin
      if (rsp_valid && !prev_valid) begin
        if (q.size() == 0) chk("unexpected_rsp_valid", 64'(1), 64'(0));
        else chk("latency", 64'(cyc - q[0].acc_cyc), 64'(W + 1));
      end
      if (busy && !rsp_valid && q.size() > 0) begin
        k = cyc - q[0].acc_cyc - 1;
        if (k >= 0 && k < int'(W)) begin
          chk("run_opsel", 64'(sl_opsel), 64'(q[0].opsel));
          chk("run_mode",  64'(sl_mode),  64'(q[0].mode));
          chk("run_op1",   64'(sl_op1),   64'(q[0].a[k]));
          chk("run_op2",   64'(sl_op2),   64'(q[0].b[k]));
          chk("run_cin",   64'(sl_cin),   64'(exp_cin(q[0], k)));
        end
      end
      if (req_ready) chk("idle_slice_zero", 64'({sl_op1, sl_op2, sl_cin}), 64'(0));
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rsp_without_request", 64'(1), 64'(0));
        else begin
          e = q.pop_front();
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_cout",   64'(rsp_cout),   64'(e.cout));
`ifdef BSALU_FLAGS_EN
          chk("rsp_zero",   64'(rsp_zero),   64'(e.zero));
          chk("rsp_ovf",    64'(rsp_ovf),    64'(e.ovf));
`endif
        end
      end
    end
    prev_valid = rsp_valid;
  end

  // Offer a request (call just after a rising edge); returns at the negedge of the accept cycle.
  task automatic send(input logic [W-1:0] a, b, input logic cin, mode,
                      input logic [2:0] op, output int acc);
    exp_t e;
    bit   done = 1'b0;
    acc = -1;
    req_a = a; req_b = b; req_cin = cin; req_mode = mode; req_opsel = op;
    req_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (req_ready) begin
        e = model(a, b, cin, mode, op);
        e.acc_cyc = cyc;
        acc = cyc;
        q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && q.size() > 0; n++) @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_result"},    64'(rsp_result), 64'(0));
    chk({tag, "_cout"},      64'(rsp_cout),  64'(0));
    chk({tag, "_slice"},     64'({sl_op1, sl_op2, sl_cin, sl_opsel, sl_mode}), 64'(0));
  endtask

  initial begin
    int   acc, prev_acc;
    exp_t e;
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0;
    req_opsel = '0; req_mode = 1'b0; req_cin = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_req_ready", 64'(req_ready), 64'(1));

    // Test 1 and 2: directed arithmetic
    @(posedge clk); #1;
    send(8'h3C, 8'h0F, 1'b0, MODE_ARITH, 3'd0, acc); idle_cycle(); drain();
    @(posedge clk); #1;
    send(8'hFF, 8'h01, 1'b0, MODE_ARITH, 3'd1, acc); idle_cycle(); drain();
    @(posedge clk); #1;
    send(8'h00, 8'h00, 1'b1, MODE_ARITH, 3'd2, acc); idle_cycle(); drain();

    // Test 3: backpressure
    ready_mode = 0;
    @(posedge clk); #1;
    e = model(8'hA5, 8'h5A, 1'b1, MODE_ARITH, 3'd3);
    send(8'hA5, 8'h5A, 1'b1, MODE_ARITH, 3'd3, acc); idle_cycle();
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
    chk("bp_valid_seen", 64'(rsp_valid), 64'(1));
    req_a = 8'h11; req_b = 8'h22; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_result_stable", 64'(rsp_result), 64'(e.res));
      chk("bp_req_ready_low", 64'(req_ready), 64'(0));
      chk("bp_valid_held",    64'(rsp_valid), 64'(1));
      @(negedge clk);
    end
    ready_mode = 1; req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_req_ready", 64'(req_ready), 64'(1));
    chk("bp_idle_valid",     64'(rsp_valid), 64'(0));
    chk("bp_result_kept",    64'(rsp_result), 64'(e.res));
    @(posedge clk); #1;
    send(8'h11, 8'h22, 1'b0, MODE_ARITH, 3'd4, acc); idle_cycle(); drain();

    // Test 4: reset at idx = 4
    @(posedge clk); #1;
    send(8'h96, 8'h69, 1'b0, MODE_ARITH, 3'd5, acc);
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0; req_valid = 1'b0;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    chk_all_zero("midrun_reset");
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_idle_ready", 64'(req_ready), 64'(1));
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    send(8'h96, 8'h69, 1'b0, MODE_ARITH, 3'd5, acc); idle_cycle(); drain();

    // Test 5: back-to-back with req_valid held
    prev_acc = -1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), acc);
      if (prev_acc >= 0) chk("b2b_spacing", 64'(acc - prev_acc), 64'(W + 2));
      prev_acc = acc;
    end
    idle_cycle(); drain();

`ifdef BSALU_FLAGS_EN
    // Test 6: flags
    @(posedge clk); #1;
    send(8'h7F, 8'h01, 1'b0, MODE_ARITH, 3'd0, acc); idle_cycle(); drain();
    chk("flag_ovf_set",  64'(rsp_ovf),  64'(1));
    chk("flag_zero_clr", 64'(rsp_zero), 64'(0));
    @(posedge clk); #1;
    send(8'hFF, 8'h01, 1'b0, MODE_ARITH, 3'd0, acc); idle_cycle(); drain();
    chk("flag_zero_set", 64'(rsp_zero), 64'(1));
    chk("flag_ovf_clr",  64'(rsp_ovf),  64'(0));
    @(posedge clk); #1;
    send(8'h7F, 8'h7F, 1'b0, MODE_LOGIC, 3'd0, acc); idle_cycle(); drain();
    chk("flag_ovf_logic", 64'(rsp_ovf), 64'(0));
`endif

    // Random operations with random response backpressure and idle gaps
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), acc);
      idle_cycle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    ready_mode = 1;
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
